// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID inputs, writeback port and ID/EX outputs of the decode stage
interface decode_stage_if;
  logic [31:0] instruction;
  logic [31:0] next_address_in;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        stall;
  logic        flush;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] extended_branch_offset;
  logic [31:0] supposed_next_address;
  logic [1:0]  ctrl_aluOp;
  logic        ctrl_aluSrc;
  logic        ctrl_regDst;
  logic        ctrl_branch;
  logic        ctrl_memRead;
  logic        ctrl_memWrite;
  logic        ctrl_memToReg;
  logic        ctrl_regWrite;
  logic [4:0]  rs_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;
  modport master (
    output instruction, next_address_in, wb_reg_write, wb_write_reg, wb_write_data, stall, flush,
    input  read_data_1, read_data_2, extended_branch_offset, supposed_next_address,
           ctrl_aluOp, ctrl_aluSrc, ctrl_regDst, ctrl_branch, ctrl_memRead, ctrl_memWrite,
           ctrl_memToReg, ctrl_regWrite, rs_out, rt_out, rd_out
  );
  modport slave (
    input  instruction, next_address_in, wb_reg_write, wb_write_reg, wb_write_data, stall, flush,
    output read_data_1, read_data_2, extended_branch_offset, supposed_next_address,
           ctrl_aluOp, ctrl_aluSrc, ctrl_regDst, ctrl_branch, ctrl_memRead, ctrl_memWrite,
           ctrl_memToReg, ctrl_regWrite, rs_out, rt_out, rd_out
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: register file with write-through bypass, control decode and ID/EX register
module decode_stage (
  input logic         clk,
  input logic         reset,
  decode_stage_if.slave bus
);
  logic [31:0] regs [32];
  logic [4:0]  rs, rt, rd;
  logic [5:0]  op;
  logic [31:0] rd1, rd2, ebo;
  logic [8:0]  ctrl;
  logic [8:0]  ctrl_q;
  assign op = bus.instruction[31:26];
  assign rs = bus.instruction[25:21];
  assign rt = bus.instruction[20:16];
  assign rd = bus.instruction[15:11];
  assign ebo = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
  // register reads, returning the writeback value when it targets the same register this cycle
  always_comb begin
    rd1 = rs == 5'd0 ? 32'd0 : (bus.wb_reg_write && bus.wb_write_reg == rs) ? bus.wb_write_data : regs[rs];
    rd2 = rt == 5'd0 ? 32'd0 : (bus.wb_reg_write && bus.wb_write_reg == rt) ? bus.wb_write_data : regs[rt];
  end
  // control word {aluOp, aluSrc, regDst, branch, memRead, memWrite, memToReg, regWrite}
  always_comb begin
    ctrl = op == 6'b000000 ? 9'b10_0100001 :
           op == 6'b100011 ? 9'b00_1001011 :
           op == 6'b101011 ? 9'b00_1000100 :
           op == 6'b000100 ? 9'b01_0010000 :
           op == 6'b001000 ? 9'b00_1000001 : 9'b0;
  end
  // register file write port; register 0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (bus.wb_reg_write && bus.wb_write_reg != 5'd0) begin
      regs[bus.wb_write_reg] <= bus.wb_write_data;
    end
  end
  // ID/EX register: flush loads a bubble ahead of stall, stall holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bus.flush) begin
      bus.read_data_1 <= '0;
      bus.read_data_2 <= '0;
      bus.extended_branch_offset <= '0;
      bus.supposed_next_address <= '0;
      ctrl_q <= '0;
      bus.rs_out <= '0;
      bus.rt_out <= '0;
      bus.rd_out <= '0;
    end else if (!bus.stall) begin
      bus.read_data_1 <= rd1;
      bus.read_data_2 <= rd2;
      bus.extended_branch_offset <= ebo;
      bus.supposed_next_address <= bus.next_address_in;
      ctrl_q <= ctrl;
      bus.rs_out <= rs;
      bus.rt_out <= rt;
      bus.rd_out <= rd;
    end
  end
  assign {bus.ctrl_aluOp, bus.ctrl_aluSrc, bus.ctrl_regDst, bus.ctrl_branch, bus.ctrl_memRead,
          bus.ctrl_memWrite, bus.ctrl_memToReg, bus.ctrl_regWrite} = ctrl_q;
endmodule
